// File: rtl/game_pkg.sv
// Shared state encoding, status codes and helpers
// for the guessing-game round controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    CHECK,
    ADVANCE,
    OVER
  } state_t;

  localparam logic [1:0] WL_LOSE = 2'd0;
  localparam logic [1:0] WL_WIN  = 2'd1;
  localparam logic [1:0] WL_PLAY = 2'd3;

  function automatic logic [6:0] time_reload(
    input logic [3:0] rnd,
    input int         d1,
    input int         d2,
    input int         d3
  );
    if (rnd <= 4'd3)
      time_reload = 7'(d1);
    else if (rnd <= 4'd6)
      time_reload = 7'(d2);
    else
      time_reload = 7'(d3);
  endfunction

  // Max_digit of 0 plays like 1 digit.
  function automatic logic [11:0] digit_mask(
    input logic [1:0] md
  );
    unique case (md)
      2'd2:    digit_mask = 12'h0FF;
      2'd3:    digit_mask = 12'hFFF;
      default: digit_mask = 12'h00F;
    endcase
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Seconds prescaler: counts enabled cycles and
// emits a 1-cycle tick every TICKS of them.
module sec_tick_gen #(
  parameter int TICKS = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_clr || o_tick)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= r_cnt + W'(1);
  end

endmodule

// File: rtl/round_ctrl.sv
// Round controller: secret fetch, guess check,
// countdown timer, round advance and game-over.
module round_ctrl
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int MAX_ROUND     = 10,
  parameter int TIME_D1       = 30,
  parameter int TIME_D2       = 60,
  parameter int TIME_D3       = 90
) (
  input  logic        clk,
  input  logic        restart,
  input  logic        start,
  input  logic        guess_valid,
  input  logic [11:0] guess_bcd,
  output logic        guess_ready,
  output logic        secret_req,
  input  logic        secret_valid,
  input  logic [11:0] secret_bcd,
  input  logic [1:0]  Max_digit,
  input  logic [1:0]  WINorLOSE,
  input  logic [2:0]  guesses_left,
  output logic [3:0]  round,
  output logic [6:0]  timer,
  output logic [2:0]  incorrect_guesses,
  output logic        correct_pulse,
  output logic        wrong_pulse,
  output logic        game_over
);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_round, w_round_nxt;
  logic [6:0]  r_timer, w_timer_nxt;
  logic [2:0]  r_inc, w_inc_nxt;
  logic [11:0] r_secret, w_secret_nxt;
  logic [11:0] r_guess, w_guess_nxt;
  logic        r_req_done, w_req_done_nxt;
  logic        w_tick, w_tick_en, w_tick_clr;
  logic        w_can_guess, w_match;
  logic [3:0]  w_round_inc;
  logic        w_unused;

  assign w_unused    = ^guesses_left;
  assign w_tick_en   = (r_state == PLAY) ||
                       (r_state == CHECK);
  assign w_can_guess = (r_timer != 7'd0) &&
                       (WINorLOSE == WL_PLAY);
  assign w_match     = ((r_secret ^ r_guess) &
                        digit_mask(Max_digit)) == 12'h000;
  assign w_round_inc = r_round + 4'd1;

  assign round             = r_round;
  assign timer             = r_timer;
  assign incorrect_guesses = r_inc;

  sec_tick_gen #(
    .TICKS (TICKS_PER_SEC)
  ) u_tick (
    .clk    (clk),
    .rst_n  (restart),
    .i_en   (w_tick_en),
    .i_clr  (w_tick_clr),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_round_nxt    = r_round;
    w_timer_nxt    = r_timer;
    w_inc_nxt      = r_inc;
    w_secret_nxt   = r_secret;
    w_guess_nxt    = r_guess;
    w_req_done_nxt = 1'b0;
    w_tick_clr     = 1'b0;
    guess_ready    = 1'b0;
    secret_req     = 1'b0;
    correct_pulse  = 1'b0;
    wrong_pulse    = 1'b0;
    game_over      = 1'b0;
    if (w_tick && (r_timer != 7'd0))
      w_timer_nxt = r_timer - 7'd1;
    unique case (r_state)
      IDLE: begin
        if (start)
          w_state_nxt = LOAD;
      end
      LOAD: begin
        secret_req     = !r_req_done;
        w_req_done_nxt = 1'b1;
        if (secret_valid) begin
          w_secret_nxt = secret_bcd;
          w_state_nxt  = PLAY;
        end
      end
      PLAY: begin
        guess_ready = w_can_guess;
        if ((r_timer == 7'd0) ||
            (WINorLOSE == WL_LOSE))
          w_state_nxt = OVER;
        else if (guess_valid && w_can_guess) begin
          w_guess_nxt = guess_bcd;
          w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (w_match) begin
          correct_pulse = 1'b1;
          w_state_nxt   = ADVANCE;
        end else begin
          wrong_pulse = 1'b1;
          if (r_inc != 3'd7)
            w_inc_nxt = r_inc + 3'd1;
          w_state_nxt = PLAY;
        end
      end
      ADVANCE: begin
        w_round_nxt = w_round_inc;
        w_inc_nxt   = 3'd0;
        w_timer_nxt = time_reload(w_round_inc,
                        TIME_D1, TIME_D2, TIME_D3);
        w_tick_clr  = 1'b1;
        w_state_nxt = (w_round_inc == 4'(MAX_ROUND)) ?
                      OVER : LOAD;
      end
      OVER: begin
        game_over = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      r_state    <= IDLE;
      r_round    <= 4'd1;
      r_timer    <= 7'(TIME_D1);
      r_inc      <= 3'd0;
      r_secret   <= 12'h000;
      r_guess    <= 12'h000;
      r_req_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_round    <= w_round_nxt;
      r_timer    <= w_timer_nxt;
      r_inc      <= w_inc_nxt;
      r_secret   <= w_secret_nxt;
      r_guess    <= w_guess_nxt;
      r_req_done <= w_req_done_nxt;
    end
  end

endmodule
